cpu_irq_sequencer: RTL

- Interrupt entry sequencer for the 6502-style CPU core. It adds the NMI/IRQ support the core lacks; today the core's set/clear-interrupt controls do nothing.
- Arbitrates one edge-triggered NMI and N_IRQ maskable level-sensitive IRQ channels.
- At an instruction boundary it takes over the memory bus and pushes PCH, PCL and P to the stack. It then fetches a per-source 16-bit vector and hands the new PC, new S and a set-I request back to the core.

---
 rtl/cpu_irq_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cpu_irq_sequencer.sv
// cpu_irq_sequencer: NMI/IRQ entry sequencer that pushes PC/P and fetches the handler vector for the 6502-style core
module cpu_irq_sequencer #(
  parameter int          N_IRQ      = 4,
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter bit          VECTORED   = 1'b0,
  parameter logic [15:0] VEC_BASE   = 16'hFFE0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nmi,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             flag_i,
  input  logic             boundary,
  input  logic [15:0]      pc_in,
  input  logic [7:0]       p_in,
  input  logic [7:0]       s_in,
  input  logic [7:0]       data_bus_in,
  output logic             busy,
  output logic [15:0]      adr_bus,
  output logic [7:0]       data_bus_out,
  output logic             RW,
  output logic [15:0]      pc_out,
  output logic             pc_load,
  output logic [7:0]       s_out,
  output logic             s_load,
  output logic             set_i,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             nmi_pending
);
  localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, DONE} state_t;
  state_t           r_state, w_next;
  logic             r_nmi_prev, r_nmi_pend, r_src_nmi;
  logic [CW-1:0]    r_ch, w_ch;
  logic [15:0]      r_pc, w_vec, w_adr, w_pc_out;
  logic [5:0]       r_p;
  logic [7:0]       r_sp, r_vlo, w_sp, w_dout, w_s_out;
  logic [N_IRQ-1:0] w_req, w_ack;
  logic             w_accept, w_busy, w_rw, w_strobe;
  assign w_req       = irq & irq_mask & {N_IRQ{~flag_i}};
  assign w_accept    = (r_state == IDLE) && boundary && (r_nmi_pend || |w_req);
  assign w_vec       = r_src_nmi ? NMI_VEC : (VECTORED ? VEC_BASE + {{(15-CW){1'b0}}, r_ch, 1'b0} : IRQ_VEC);
  assign nmi_pending = r_nmi_pend;
  // lowest-index enabled channel wins among maskable requests
  always_comb begin
    w_ch = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) if (w_req[k]) w_ch = CW'(k);
  end
  // state register; reset abandons any partially pushed frame
  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state plus the next bus/strobe values, registered below
  always_comb begin
    w_next   = r_state;
    w_busy   = busy;
    w_adr    = adr_bus;
    w_dout   = data_bus_out;
    w_rw     = RW;
    w_sp     = r_sp;
    w_pc_out = pc_out;
    w_s_out  = s_out;
    w_strobe = 1'b0;
    w_ack    = {N_IRQ{1'b0}};
    case (r_state)
      IDLE: begin
        w_next = w_accept ? PUSH_PCH : IDLE;
        w_busy = w_accept ? 1'b1 : busy;
        w_sp   = w_accept ? s_in : r_sp;
      end
      PUSH_PCH: begin
        w_next = PUSH_PCL;
        w_adr  = {STACK_PAGE, r_sp};
        w_dout = r_pc[15:8];
        w_rw   = 1'b0;
        w_sp   = r_sp - 8'd1;
      end
      PUSH_PCL: begin
        w_next = PUSH_P;
        w_adr  = {STACK_PAGE, r_sp};
        w_dout = r_pc[7:0];
        w_rw   = 1'b0;
        w_sp   = r_sp - 8'd1;
      end
      PUSH_P: begin
        w_next = VEC_LO;
        w_adr  = {STACK_PAGE, r_sp};
        w_dout = {r_p[5:4], 2'b10, r_p[3:0]};
        w_rw   = 1'b0;
        w_sp   = r_sp - 8'd1;
      end
      VEC_LO: begin
        w_next = VEC_HI;
        w_adr  = w_vec;
        w_rw   = 1'b1;
      end
      VEC_HI: begin
        w_next = DONE;
        w_adr  = w_vec + 16'd1;
      end
      DONE: begin
        w_next   = IDLE;
        w_pc_out = {data_bus_in, r_vlo};
        w_s_out  = r_sp;
        w_strobe = 1'b1;
        w_ack    = r_src_nmi ? {N_IRQ{1'b0}} : N_IRQ'(1) << r_ch;
        w_busy   = 1'b0;
        w_rw     = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  // datapath: source latch at acceptance, NMI edge capture and registered bus outputs
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      adr_bus      <= '0;
      data_bus_out <= '0;
      RW           <= 1'b1;
      pc_out       <= '0;
      s_out        <= '0;
      pc_load      <= 1'b0;
      s_load       <= 1'b0;
      set_i        <= 1'b0;
      irq_ack      <= '0;
      r_nmi_prev   <= 1'b0;
      r_nmi_pend   <= 1'b0;
      r_src_nmi    <= 1'b0;
      r_ch         <= '0;
      r_pc         <= '0;
      r_p          <= '0;
      r_sp         <= '0;
      r_vlo        <= '0;
    end else begin
      busy         <= w_busy;
      adr_bus      <= w_adr;
      data_bus_out <= w_dout;
      RW           <= w_rw;
      pc_out       <= w_pc_out;
      s_out        <= w_s_out;
      pc_load      <= w_strobe;
      s_load       <= w_strobe;
      set_i        <= w_strobe;
      irq_ack      <= w_ack;
      r_nmi_prev   <= nmi;
      r_nmi_pend   <= (nmi & ~r_nmi_prev) | (r_nmi_pend & ~w_accept);
      r_src_nmi    <= w_accept ? r_nmi_pend : r_src_nmi;
      r_ch         <= w_accept ? w_ch : r_ch;
      r_pc         <= w_accept ? pc_in : r_pc;
      r_p          <= w_accept ? {p_in[7:6], p_in[3:0]} : r_p;
      r_sp         <= w_sp;
      r_vlo        <= (r_state == VEC_HI) ? data_bus_in : r_vlo;
    end
  end
endmodule
